// File: rtl/branch_target_buffer_if.sv
// Fetch-lookup, prediction and execute-update signal group for the branch target buffer.
// master drives requests and updates; slave is the BTB itself.
interface branch_target_buffer_if;
    logic        flush;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        pred_valid;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_tgt_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_cond;
    logic        upd_is_jump;
    logic        upd_taken;
    logic [31:0] upd_tgt_pc;

    modport master (
        output flush, lookup_valid, lookup_pc,
        output upd_valid, upd_pc, upd_is_cond, upd_is_jump, upd_taken, upd_tgt_pc,
        input  pred_valid, pred_hit, pred_taken, pred_tgt_pc
    );

    modport slave (
        input  flush, lookup_valid, lookup_pc,
        input  upd_valid, upd_pc, upd_is_cond, upd_is_jump, upd_taken, upd_tgt_pc,
        output pred_valid, pred_hit, pred_taken, pred_tgt_pc
    );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// One registered lookup and one update per cycle; lookups see pre-update contents.
module branch_target_buffer #(
    parameter int unsigned ENTRIES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_target_buffer_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    logic [ENTRIES-1:0] r_valid;
    logic [1:0]         r_ctr [ENTRIES];
    logic [TAG_W-1:0]   r_tag [ENTRIES];
    logic [31:0]        r_tgt [ENTRIES];

    logic        r_pred_valid;
    logic        r_pred_hit;
    logic        r_pred_taken;
    logic [31:0] r_pred_tgt_pc;

    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic             w_lk_hit;
    logic             w_lk_taken;
    logic [31:0]      w_lk_tgt;

    logic [IDX_W-1:0] w_upd_idx;
    logic [TAG_W-1:0] w_upd_tag;
    logic             w_upd_hit;
    logic             w_alloc;
    logic             w_tgt_we;
    logic             w_ctr_we;
    logic [1:0]       w_ctr_cur;
    logic [1:0]       w_ctr_new;
    logic [3:0]       w_unused_pc_lsb;

    assign w_unused_pc_lsb = {bus.lookup_pc[1:0], bus.upd_pc[1:0]};

    assign w_lk_idx   = bus.lookup_pc[IDX_W+1:2];
    assign w_lk_tag   = bus.lookup_pc[31:IDX_W+2];
    assign w_lk_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign w_lk_taken = w_lk_hit && r_ctr[w_lk_idx][1];
    assign w_lk_tgt   = w_lk_taken ? r_tgt[w_lk_idx] : (bus.lookup_pc + 32'd4);

    assign w_upd_idx = bus.upd_pc[IDX_W+1:2];
    assign w_upd_tag = bus.upd_pc[31:IDX_W+2];
    assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    assign w_ctr_cur = r_ctr[w_upd_idx];

    // Jump takes priority over cond when both flags are set.
    always_comb begin
        w_alloc   = 1'b0;
        w_tgt_we  = 1'b0;
        w_ctr_we  = 1'b0;
        w_ctr_new = w_ctr_cur;
        if (bus.upd_valid) begin
            if (bus.upd_is_jump) begin
                w_alloc   = 1'b1;
                w_tgt_we  = 1'b1;
                w_ctr_we  = 1'b1;
                w_ctr_new = 2'b11;
            end else if (bus.upd_is_cond) begin
                if (w_upd_hit) begin
                    w_ctr_we = 1'b1;
                    if (bus.upd_taken) begin
                        w_tgt_we  = 1'b1;
                        w_ctr_new = (w_ctr_cur == 2'b11) ? 2'b11 : w_ctr_cur + 2'd1;
                    end else begin
                        w_ctr_new = (w_ctr_cur == 2'b00) ? 2'b00 : w_ctr_cur - 2'd1;
                    end
                end else if (bus.upd_taken) begin
                    w_alloc   = 1'b1;
                    w_tgt_we  = 1'b1;
                    w_ctr_we  = 1'b1;
                    w_ctr_new = 2'b10;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= 2'b00;
            end
        end else if (bus.flush) begin
            r_valid <= '0;
        end else begin
            if (w_alloc) begin
                r_valid[w_upd_idx] <= 1'b1;
            end
            if (w_ctr_we) begin
                r_ctr[w_upd_idx] <= w_ctr_new;
            end
        end
    end

    // Tag/target storage carries no reset; it is masked by r_valid.
    always_ff @(posedge clk) begin
        if (!bus.flush) begin
            if (w_alloc) begin
                r_tag[w_upd_idx] <= w_upd_tag;
            end
            if (w_tgt_we) begin
                r_tgt[w_upd_idx] <= bus.upd_tgt_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pred_valid  <= 1'b0;
            r_pred_hit    <= 1'b0;
            r_pred_taken  <= 1'b0;
            r_pred_tgt_pc <= '0;
        end else if (bus.flush || !bus.lookup_valid) begin
            r_pred_valid  <= 1'b0;
            r_pred_hit    <= 1'b0;
            r_pred_taken  <= 1'b0;
            r_pred_tgt_pc <= '0;
        end else begin
            r_pred_valid  <= 1'b1;
            r_pred_hit    <= w_lk_hit;
            r_pred_taken  <= w_lk_taken;
            r_pred_tgt_pc <= w_lk_tgt;
        end
    end

    assign bus.pred_valid  = r_pred_valid;
    assign bus.pred_hit    = r_pred_hit;
    assign bus.pred_taken  = r_pred_taken;
    assign bus.pred_tgt_pc = r_pred_tgt_pc;
endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed-vector bench for branch_target_buffer (ENTRIES=16).
// Observed word is {pred_valid, pred_hit, pred_taken, pred_tgt_pc}.
module tb_branch_target_buffer;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    branch_target_buffer_if bus ();

    branch_target_buffer #(.ENTRIES(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [34:0] obs;
    assign obs = {bus.pred_valid, bus.pred_hit, bus.pred_taken, bus.pred_tgt_pc};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.flush        = 1'b0;
        bus.lookup_valid = 1'b0;
        bus.lookup_pc    = '0;
        bus.upd_valid    = 1'b0;
        bus.upd_pc       = '0;
        bus.upd_is_cond  = 1'b0;
        bus.upd_is_jump  = 1'b0;
        bus.upd_taken    = 1'b0;
        bus.upd_tgt_pc   = '0;
    endtask

    task automatic do_upd(input logic [31:0] pc, input logic cond, input logic jump,
                          input logic taken, input logic [31:0] tgt);
        bus.upd_valid   = 1'b1;
        bus.upd_pc      = pc;
        bus.upd_is_cond = cond;
        bus.upd_is_jump = jump;
        bus.upd_taken   = taken;
        bus.upd_tgt_pc  = tgt;
        tick();
        bus.upd_valid   = 1'b0;
    endtask

    task automatic do_lookup(input logic [31:0] pc);
        bus.lookup_valid = 1'b1;
        bus.lookup_pc    = pc;
        tick();
        bus.lookup_valid = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 1'b0;
        tick();
        tick();
        n_tests++;
        if (obs !== 35'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected %h", obs, 35'h0);
        end
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (obs !== 35'h0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %h expected %h", obs, 35'h0);
        end
    endtask

    task automatic test_cold_lookup();
        do_lookup(32'h0000_0100);
        n_tests++;
        if (obs !== {3'b100, 32'h0000_0104}) begin
            n_fail++;
            $display("FAIL cold_lookup: got %h expected %h", obs, {3'b100, 32'h0000_0104});
        end
        tick();
        n_tests++;
        if (obs !== 35'h0) begin
            n_fail++;
            $display("FAIL idle_zero: got %h expected %h", obs, 35'h0);
        end
    endtask

    task automatic test_alloc_train();
        do_upd(32'h0000_0100, 1'b1, 1'b0, 1'b1, 32'h0000_0080);
        do_lookup(32'h0000_0100);
        n_tests++;
        if (obs !== {3'b111, 32'h0000_0080}) begin
            n_fail++;
            $display("FAIL alloc_hit: got %h expected %h", obs, {3'b111, 32'h0000_0080});
        end
        do_upd(32'h0000_0100, 1'b1, 1'b0, 1'b0, 32'h0000_0000);
        do_upd(32'h0000_0100, 1'b1, 1'b0, 1'b0, 32'h0000_0000);
        do_lookup(32'h0000_0100);
        n_tests++;
        if (obs !== {3'b110, 32'h0000_0104}) begin
            n_fail++;
            $display("FAIL train_to_snt: got %h expected %h", obs, {3'b110, 32'h0000_0104});
        end
        // 00 stays 00 on not-taken, so one taken lands at 01 (still not taken)
        do_upd(32'h0000_0100, 1'b1, 1'b0, 1'b0, 32'h0000_0000);
        do_upd(32'h0000_0100, 1'b1, 1'b0, 1'b1, 32'h0000_0090);
        do_lookup(32'h0000_0100);
        n_tests++;
        if (obs !== {3'b110, 32'h0000_0104}) begin
            n_fail++;
            $display("FAIL sat_low: got %h expected %h", obs, {3'b110, 32'h0000_0104});
        end
        do_upd(32'h0000_0100, 1'b1, 1'b0, 1'b1, 32'h0000_0090);
        do_lookup(32'h0000_0100);
        n_tests++;
        if (obs !== {3'b111, 32'h0000_0090}) begin
            n_fail++;
            $display("FAIL retarget: got %h expected %h", obs, {3'b111, 32'h0000_0090});
        end
    endtask

    task automatic test_saturation();
        // entry at 0x100 is at counter 10
        for (int i = 0; i < 5; i++) do_upd(32'h0000_0100, 1'b1, 1'b0, 1'b1, 32'h0000_0090);
        do_upd(32'h0000_0100, 1'b1, 1'b0, 1'b0, 32'h0000_0000);
        do_lookup(32'h0000_0100);
        n_tests++;
        if (obs !== {3'b111, 32'h0000_0090}) begin
            n_fail++;
            $display("FAIL sat_high5: got %h expected %h", obs, {3'b111, 32'h0000_0090});
        end
        for (int i = 0; i < 3; i++) do_upd(32'h0000_0100, 1'b1, 1'b0, 1'b1, 32'h0000_0090);
        do_upd(32'h0000_0100, 1'b1, 1'b0, 1'b0, 32'h0000_0000);
        do_lookup(32'h0000_0100);
        n_tests++;
        if (obs !== {3'b111, 32'h0000_0090}) begin
            n_fail++;
            $display("FAIL sat_high3: got %h expected %h", obs, {3'b111, 32'h0000_0090});
        end
        do_upd(32'h0000_0100, 1'b1, 1'b0, 1'b0, 32'h0000_0000);
        do_lookup(32'h0000_0100);
        n_tests++;
        if (obs !== {3'b110, 32'h0000_0104}) begin
            n_fail++;
            $display("FAIL wnt_after_dec: got %h expected %h", obs, {3'b110, 32'h0000_0104});
        end
    endtask

    task automatic test_update_kinds();
        do_upd(32'h0000_0304, 1'b1, 1'b0, 1'b0, 32'h0000_1111);
        do_lookup(32'h0000_0304);
        n_tests++;
        if (obs !== {3'b100, 32'h0000_0308}) begin
            n_fail++;
            $display("FAIL nt_miss_no_alloc: got %h expected %h", obs, {3'b100, 32'h0000_0308});
        end
        do_upd(32'h0000_0408, 1'b0, 1'b0, 1'b1, 32'h0000_2222);
        do_lookup(32'h0000_0408);
        n_tests++;
        if (obs !== {3'b100, 32'h0000_040C}) begin
            n_fail++;
            $display("FAIL non_branch_ignored: got %h expected %h", obs, {3'b100, 32'h0000_040C});
        end
        do_upd(32'h0000_050C, 1'b1, 1'b1, 1'b0, 32'h0000_5554);
        do_lookup(32'h0000_050C);
        n_tests++;
        if (obs !== {3'b111, 32'h0000_5554}) begin
            n_fail++;
            $display("FAIL both_as_jump: got %h expected %h", obs, {3'b111, 32'h0000_5554});
        end
    endtask

    task automatic test_alias();
        do_upd(32'h0000_0100, 1'b0, 1'b1, 1'b1, 32'h0000_2000);
        do_upd(32'h0000_0140, 1'b0, 1'b1, 1'b1, 32'h0000_3000);
        do_lookup(32'h0000_0100);
        n_tests++;
        if (obs !== {3'b100, 32'h0000_0104}) begin
            n_fail++;
            $display("FAIL alias_evicted: got %h expected %h", obs, {3'b100, 32'h0000_0104});
        end
        do_lookup(32'h0000_0140);
        n_tests++;
        if (obs !== {3'b111, 32'h0000_3000}) begin
            n_fail++;
            $display("FAIL alias_new: got %h expected %h", obs, {3'b111, 32'h0000_3000});
        end
    endtask

    task automatic test_collision();
        bus.lookup_valid = 1'b1;
        bus.lookup_pc    = 32'h0000_0600;
        do_upd(32'h0000_0600, 1'b1, 1'b0, 1'b1, 32'h0000_7000);
        bus.lookup_valid = 1'b0;
        n_tests++;
        if (obs !== {3'b100, 32'h0000_0604}) begin
            n_fail++;
            $display("FAIL same_cycle_rbw: got %h expected %h", obs, {3'b100, 32'h0000_0604});
        end
        do_lookup(32'h0000_0600);
        n_tests++;
        if (obs !== {3'b111, 32'h0000_7000}) begin
            n_fail++;
            $display("FAIL after_collision: got %h expected %h", obs, {3'b111, 32'h0000_7000});
        end
    endtask

    task automatic test_back_to_back();
        bus.lookup_valid = 1'b1;
        bus.lookup_pc    = 32'h0000_0600;
        tick();
        n_tests++;
        if (obs !== {3'b111, 32'h0000_7000}) begin
            n_fail++;
            $display("FAIL b2b_first: got %h expected %h", obs, {3'b111, 32'h0000_7000});
        end
        bus.lookup_pc = 32'h0000_0614;
        tick();
        bus.lookup_valid = 1'b0;
        n_tests++;
        if (obs !== {3'b100, 32'h0000_0618}) begin
            n_fail++;
            $display("FAIL b2b_second: got %h expected %h", obs, {3'b100, 32'h0000_0618});
        end
        tick();
        n_tests++;
        if (obs !== 35'h0) begin
            n_fail++;
            $display("FAIL b2b_drop: got %h expected %h", obs, 35'h0);
        end
    endtask

    task automatic test_flush();
        do_upd(32'h0000_0708, 1'b0, 1'b1, 1'b1, 32'h0000_8888);
        do_lookup(32'h0000_0708);
        n_tests++;
        if (obs !== {3'b111, 32'h0000_8888}) begin
            n_fail++;
            $display("FAIL pre_flush_hit: got %h expected %h", obs, {3'b111, 32'h0000_8888});
        end
        bus.flush        = 1'b1;
        bus.lookup_valid = 1'b1;
        bus.lookup_pc    = 32'h0000_0708;
        do_upd(32'h0000_070C, 1'b0, 1'b1, 1'b1, 32'h0000_9999);
        bus.flush        = 1'b0;
        bus.lookup_valid = 1'b0;
        n_tests++;
        if (obs !== 35'h0) begin
            n_fail++;
            $display("FAIL flush_cycle_lookup: got %h expected %h", obs, 35'h0);
        end
        do_lookup(32'h0000_0708);
        n_tests++;
        if (obs !== {3'b100, 32'h0000_070C}) begin
            n_fail++;
            $display("FAIL flush_cleared: got %h expected %h", obs, {3'b100, 32'h0000_070C});
        end
        do_lookup(32'h0000_070C);
        n_tests++;
        if (obs !== {3'b100, 32'h0000_0710}) begin
            n_fail++;
            $display("FAIL flush_beats_update: got %h expected %h", obs, {3'b100, 32'h0000_0710});
        end
        do_lookup(32'h0000_0140);
        n_tests++;
        if (obs !== {3'b100, 32'h0000_0144}) begin
            n_fail++;
            $display("FAIL flush_other_entry: got %h expected %h", obs, {3'b100, 32'h0000_0144});
        end
    endtask

    task automatic test_wrap();
        do_lookup(32'hFFFF_FFFC);
        n_tests++;
        if (obs !== {3'b100, 32'h0000_0000}) begin
            n_fail++;
            $display("FAIL pc_wrap: got %h expected %h", obs, {3'b100, 32'h0000_0000});
        end
    endtask

    task automatic test_reset_mid();
        do_upd(32'h0000_0800, 1'b0, 1'b1, 1'b1, 32'h0000_AAAA);
        do_lookup(32'h0000_0800);
        n_tests++;
        if (obs !== {3'b111, 32'h0000_AAAA}) begin
            n_fail++;
            $display("FAIL pre_reset_hit: got %h expected %h", obs, {3'b111, 32'h0000_AAAA});
        end
        bus.lookup_valid = 1'b1;
        bus.lookup_pc    = 32'h0000_0800;
        tick();
        bus.upd_valid   = 1'b1;
        bus.upd_pc      = 32'h0000_0904;
        bus.upd_is_jump = 1'b1;
        bus.upd_taken   = 1'b1;
        bus.upd_tgt_pc  = 32'h0000_BBBB;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (obs !== 35'h0) begin
            n_fail++;
            $display("FAIL async_reset_clear: got %h expected %h", obs, 35'h0);
        end
        tick();
        set_idle();
        rst_n = 1'b1;
        tick();
        do_lookup(32'h0000_0800);
        n_tests++;
        if (obs !== {3'b100, 32'h0000_0804}) begin
            n_fail++;
            $display("FAIL reset_invalidates: got %h expected %h", obs, {3'b100, 32'h0000_0804});
        end
        do_lookup(32'h0000_0904);
        n_tests++;
        if (obs !== {3'b100, 32'h0000_0908}) begin
            n_fail++;
            $display("FAIL reset_blocks_update: got %h expected %h", obs, {3'b100, 32'h0000_0908});
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_cold_lookup();
        test_alloc_train();
        test_saturation();
        test_update_kinds();
        test_alias();
        test_collision();
        test_back_to_back();
        test_flush();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
